// File: rtl/csr_timer_bank_pkg.sv
// Shared constants and helpers for the CSR timer bank: register offsets
// within a channel's address window and TCFG/TICLR bit positions.
package csr_timer_bank_pkg;

  localparam logic [13:0] TCFG_OFS  = 14'd0;
  localparam logic [13:0] TVAL_OFS  = 14'd1;
  localparam logic [13:0] TICLR_OFS = 14'd2;

  localparam int unsigned TCFG_EN       = 0;
  localparam int unsigned TCFG_PERIODIC = 1;
  localparam int unsigned TICLR_CLR     = 0;

  function automatic logic [31:0] csr_merge(input logic [31:0] mask,
                                            input logic [31:0] wvalue,
                                            input logic [31:0] old);
    return (mask & wvalue) | (~mask & old);
  endfunction

endpackage

// File: rtl/csr_timer_bank_if.sv
// CSR read/write port shared with the main CSR file; the WB stage is the
// master, the timer bank is a slave.
interface csr_timer_bank_if;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        csr_hit;

  modport master (
    output csr_we, csr_num, csr_wmask, csr_wvalue,
    input  csr_rvalue, csr_hit
  );

  modport slave (
    input  csr_we, csr_num, csr_wmask, csr_wvalue,
    output csr_rvalue, csr_hit
  );
endinterface

// File: rtl/csr_timer_chan.sv
// One timer channel: TCFG register, down counter, pending bit and the
// decode of its three CSR addresses.
module csr_timer_chan
  import csr_timer_bank_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter logic [13:0] TCFG_ADDR = 14'h041,
  parameter bit          SET_WINS  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we_i,
  input  logic [13:0] csr_num_i,
  input  logic [31:0] csr_wmask_i,
  input  logic [31:0] csr_wvalue_i,
  input  logic        stall_i,
  output logic [31:0] rvalue_o,
  output logic        hit_o,
  output logic        irq_o
);

  logic [CNT_W-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;

  logic sel_tcfg, sel_tval, sel_ticlr;
  logic cfg_wr, clr, counting, cnt_zero, set_pend;

  assign sel_tcfg  = (csr_num_i == TCFG_ADDR + TCFG_OFS);
  assign sel_tval  = (csr_num_i == TCFG_ADDR + TVAL_OFS);
  assign sel_ticlr = (csr_num_i == TCFG_ADDR + TICLR_OFS);
  assign hit_o     = sel_tcfg | sel_tval | sel_ticlr;

  assign cfg_wr   = csr_we_i & sel_tcfg;
  assign clr      = csr_we_i & sel_ticlr & csr_wmask_i[TICLR_CLR] & csr_wvalue_i[TICLR_CLR];
  assign cnt_zero = (cnt_q == '0);
  assign counting = cfg_q[TCFG_EN] & ~stall_i & (cnt_q != '1);
  assign set_pend = cfg_q[TCFG_EN] & ~stall_i & cnt_zero;

  assign cfg_d = cfg_wr ? CNT_W'(csr_merge(csr_wmask_i, csr_wvalue_i, 32'(cfg_q))) : cfg_q;

  // A TCFG write always overrides counting: EN=1 reloads, EN=0 freezes.
  always_comb begin
    cnt_d = cnt_q;
    if (cfg_wr) begin
      if (cfg_d[TCFG_EN]) cnt_d = {cfg_d[CNT_W-1:2], 2'b00};
    end else if (counting) begin
      if (cnt_zero && cfg_q[TCFG_PERIODIC]) cnt_d = {cfg_q[CNT_W-1:2], 2'b00};
      else                                  cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (set_pend && clr) pend_d = SET_WINS;
    else if (set_pend)   pend_d = 1'b1;
    else if (clr)        pend_d = 1'b0;
  end

  always_comb begin
    rvalue_o = '0;
    if (sel_tcfg)      rvalue_o = 32'(cfg_q);
    else if (sel_tval) rvalue_o = 32'(cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q  <= '0;
      cnt_q  <= '1;
      pend_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign irq_o = pend_q;

endmodule

// File: rtl/csr_timer_bank.sv
// Multi-channel timer CSR block beside the main CSR file: per-channel
// timers, OR-combined read data, and a free-running 64-bit stable counter.
module csr_timer_bank
  import csr_timer_bank_pkg::*;
#(
  parameter int unsigned N_TIMERS = 4,
  parameter int unsigned CNT_W    = 32,
  parameter logic [13:0] CSR_BASE = 14'h041,
  parameter bit          SET_WINS = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  csr_timer_bank_if.slave     csr,
  input  logic                timer_stall,
  output logic [N_TIMERS-1:0] timer_irq,
  output logic [63:0]         stable_cnt
);

  logic [31:0]         ch_rvalue [N_TIMERS];
  logic [N_TIMERS-1:0] ch_hit;
  logic [31:0]         rvalue_or;
  logic [63:0]         stable_q;

  for (genvar c = 0; c < N_TIMERS; c++) begin : g_chan
    csr_timer_chan #(
      .CNT_W    (CNT_W),
      .TCFG_ADDR(CSR_BASE + 14'(4 * c)),
      .SET_WINS (SET_WINS)
    ) u_chan (
      .clk         (clk),
      .rst         (reset),
      .csr_we_i    (csr.csr_we),
      .csr_num_i   (csr.csr_num),
      .csr_wmask_i (csr.csr_wmask),
      .csr_wvalue_i(csr.csr_wvalue),
      .stall_i     (timer_stall),
      .rvalue_o    (ch_rvalue[c]),
      .hit_o       (ch_hit[c]),
      .irq_o       (timer_irq[c])
    );
  end

  // Channel windows never overlap, so at most one channel drives nonzero data.
  always_comb begin
    rvalue_or = '0;
    for (int unsigned c = 0; c < N_TIMERS; c++) rvalue_or |= ch_rvalue[c];
  end

  assign csr.csr_rvalue = rvalue_or;
  assign csr.csr_hit    = |ch_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stable_q <= '0;
    else       stable_q <= stable_q + 64'd1;
  end

  assign stable_cnt = stable_q;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Bench for csr_timer_bank: two instances (set-wins / clear-wins) share one
// stimulus stream and are checked against an arithmetic reference model.
module tb_csr_timer_bank;

  localparam logic [13:0] BASE = 14'h041;
  localparam int NT = 4;

  logic clk, reset, stall;
  logic [NT-1:0] irq_a, irq_b;
  logic [63:0]   stab_a, stab_b;

  csr_timer_bank_if bus_a ();
  csr_timer_bank_if bus_b ();

  assign bus_b.csr_we     = bus_a.csr_we;
  assign bus_b.csr_num    = bus_a.csr_num;
  assign bus_b.csr_wmask  = bus_a.csr_wmask;
  assign bus_b.csr_wvalue = bus_a.csr_wvalue;

  csr_timer_bank #(.N_TIMERS(NT), .CNT_W(32), .CSR_BASE(BASE), .SET_WINS(1'b1)) u_dut_set (
    .clk(clk), .reset(reset), .csr(bus_a), .timer_stall(stall),
    .timer_irq(irq_a), .stable_cnt(stab_a)
  );

  csr_timer_bank #(.N_TIMERS(NT), .CNT_W(32), .CSR_BASE(BASE), .SET_WINS(1'b0)) u_dut_clr (
    .clk(clk), .reset(reset), .csr(bus_b), .timer_stall(stall),
    .timer_irq(irq_b), .stable_cnt(stab_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_pend[0] is set-wins, m_pend[1] is clear-wins.
  logic [31:0] m_cfg [NT];
  logic [31:0] m_cnt [NT];
  bit          m_pend [2][NT];
  logic [63:0] m_stable;

  always @(posedge clk or posedge reset) begin
    logic [13:0] a;
    bit wr, clr, fire;
    if (reset) begin
      for (int c = 0; c < NT; c++) begin
        m_cfg[c] = 32'h0;
        m_cnt[c] = 32'hFFFF_FFFF;
        m_pend[0][c] = 1'b0;
        m_pend[1][c] = 1'b0;
      end
      m_stable = 64'h0;
    end else begin
      m_stable = m_stable + 64'd1;
      for (int c = 0; c < NT; c++) begin
        a    = BASE + 14'(4 * c);
        wr   = bus_a.csr_we && bus_a.csr_num == a;
        clr  = bus_a.csr_we && bus_a.csr_num == a + 14'd2 &&
               bus_a.csr_wmask[0] && bus_a.csr_wvalue[0];
        fire = m_cfg[c][0] && !stall && m_cnt[c] == 32'h0;
        if (wr) begin
          m_cfg[c] = (bus_a.csr_wmask & bus_a.csr_wvalue) | (~bus_a.csr_wmask & m_cfg[c]);
          if (m_cfg[c][0]) m_cnt[c] = m_cfg[c] & 32'hFFFF_FFFC;
        end else if (m_cfg[c][0] && !stall && m_cnt[c] != 32'hFFFF_FFFF) begin
          if (m_cnt[c] == 32'h0)
            m_cnt[c] = m_cfg[c][1] ? (m_cfg[c] & 32'hFFFF_FFFC) : 32'hFFFF_FFFF;
          else
            m_cnt[c] = m_cnt[c] - 32'd1;
        end
        m_pend[0][c] = fire ? 1'b1 : (clr ? 1'b0 : m_pend[0][c]);
        m_pend[1][c] = clr ? 1'b0 : (fire ? 1'b1 : m_pend[1][c]);
      end
    end
  end

  function automatic void model_read(input logic [13:0] num, output logic [31:0] rv, output bit hit);
    int unsigned ofs;
    rv  = 32'h0;
    hit = 1'b0;
    if (num >= BASE && num < BASE + 14'(4 * NT)) begin
      ofs = 32'(num - BASE);
      hit = (ofs % 4) != 3;
      if (ofs % 4 == 0)      rv = m_cfg[ofs / 4];
      else if (ofs % 4 == 1) rv = m_cnt[ofs / 4];
    end
  endfunction

  always @(negedge clk) begin
    logic [31:0] erv;
    bit ehit;
    logic [NT-1:0] eia, eib;
    if (chk_en) begin
      model_read(bus_a.csr_num, erv, ehit);
      for (int c = 0; c < NT; c++) begin
        eia[c] = m_pend[0][c];
        eib[c] = m_pend[1][c];
      end
      check("rvalue_set", bus_a.csr_rvalue, erv);
      check("rvalue_clr", bus_b.csr_rvalue, erv);
      check("hit_set", bus_a.csr_hit, ehit);
      check("hit_clr", bus_b.csr_hit, ehit);
      check("irq_set", irq_a, eia);
      check("irq_clr", irq_b, eib);
      check("stable_set", stab_a, m_stable);
      check("stable_clr", stab_b, m_stable);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit w, input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
    bus_a.csr_we     = w;
    bus_a.csr_num    = n;
    bus_a.csr_wmask  = m;
    bus_a.csr_wvalue = v;
  endtask

  task automatic rd(input logic [13:0] n);
    bus_a.csr_we  = 1'b0;
    bus_a.csr_num = n;
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] s0;
    reset = 1'b1;
    stall = 1'b0;
    drive(1'b0, BASE, 32'h0, 32'h0);
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    rd(BASE + 14'd1);
    check("reset_tval", bus_a.csr_rvalue, 32'hFFFF_FFFF);
    check("reset_irq", irq_a, 4'h0);

    // One-shot, channel 0
    drive(1'b1, BASE, 32'hFFFF_FFFF, 32'h0000_000D);
    step();
    for (int i = 0; i < 13; i++) begin
      rd(BASE + 14'd1);
      check("oneshot_tval", bus_a.csr_rvalue, 64'(12 - i));
      check("oneshot_irq_low", irq_a[0], 1'b0);
      step();
    end
    rd(BASE + 14'd1);
    check("oneshot_tval_end", bus_a.csr_rvalue, 32'hFFFF_FFFF);
    check("oneshot_irq_high", irq_a[0], 1'b1);
    step();
    rd(BASE + 14'd1);
    check("oneshot_tval_hold", bus_a.csr_rvalue, 32'hFFFF_FFFF);
    check("oneshot_irq_hold", irq_a[0], 1'b1);

    // Periodic, channel 2
    drive(1'b1, BASE + 14'd8, 32'hFFFF_FFFF, 32'h0000_000B);
    step();
    for (int i = 0; i < 9; i++) begin
      rd(BASE + 14'd9);
      check("per_tval", bus_a.csr_rvalue, 64'(8 - i));
      check("per_irq_low", irq_a[2], 1'b0);
      step();
    end
    rd(BASE + 14'd9);
    check("per_reload", bus_a.csr_rvalue, 32'd8);
    check("per_irq_set", irq_a[2], 1'b1);
    drive(1'b1, BASE + 14'd10, 32'h1, 32'h1);
    step();
    for (int i = 7; i >= 0; i--) begin
      rd(BASE + 14'd9);
      check("per_tval2", bus_a.csr_rvalue, 64'(i));
      check("per_irq_cleared", irq_a[2], 1'b0);
      if (i > 0) step();
    end
    drive(1'b1, BASE + 14'd10, 32'h1, 32'h1);
    step();
    rd(BASE + 14'd9);
    check("collide_tval", bus_a.csr_rvalue, 32'd8);
    check("collide_set_wins", irq_a[2], 1'b1);
    check("collide_clr_wins", irq_b[2], 1'b0);

    // Stall, channel 1
    drive(1'b1, BASE + 14'd4, 32'hFFFF_FFFF, 32'h0000_0009);
    step();
    rd(BASE + 14'd5);
    step();
    rd(BASE + 14'd5);
    check("stall_pre", bus_a.csr_rvalue, 32'd7);
    s0 = m_stable;
    stall = 1'b1;
    repeat (5) begin
      step();
      rd(BASE + 14'd5);
      check("stall_tval", bus_a.csr_rvalue, 32'd7);
    end
    check("stall_stable", stab_a, s0 + 64'd5);
    stall = 1'b0;
    step();
    rd(BASE + 14'd5);
    check("stall_resume", bus_a.csr_rvalue, 32'd6);

    // Masked write, channel 3
    drive(1'b1, BASE + 14'd12, 32'hFFFF_FFFF, 32'h0000_0021);
    step();
    rd(BASE + 14'd13);
    check("mask_load", bus_a.csr_rvalue, 32'd32);
    step();
    step();
    rd(BASE + 14'd13);
    check("mask_count", bus_a.csr_rvalue, 32'd30);
    drive(1'b1, BASE + 14'd12, 32'h2, 32'h0);
    step();
    rd(BASE + 14'd13);
    check("mask_reload", bus_a.csr_rvalue, 32'd32);
    rd(BASE + 14'd12);
    check("mask_tcfg", bus_a.csr_rvalue, 32'h21);

    // Asynchronous reset mid-count
    step();
    reset = 1'b1;
    rd(BASE + 14'd13);
    check("areset_tval", bus_a.csr_rvalue, 32'hFFFF_FFFF);
    check("areset_irq", irq_a, 4'h0);
    check("areset_stable", stab_a, 64'h0);
    rd(BASE + 14'd3);
    check("unmapped_rv", bus_a.csr_rvalue, 32'h0);
    check("unmapped_hit", bus_a.csr_hit, 1'b0);
    rd(BASE);
    check("mapped_hit", bus_a.csr_hit, 1'b1);
    step();
    reset = 1'b0;
    step();
    step();
    rd(BASE + 14'd13);
    check("post_reset_idle", bus_a.csr_rvalue, 32'hFFFF_FFFF);

    // Randomized traffic
    repeat (3000) begin
      bus_a.csr_we     = $urandom_range(0, 99) < 40;
      bus_a.csr_num    = BASE - 14'd2 + 14'($urandom_range(0, 21));
      bus_a.csr_wmask  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'hFFFF_FFFF;
      bus_a.csr_wvalue = ($urandom_range(0, 15) == 0) ? 32'($urandom)
                         : 32'(($urandom_range(0, 5) << 2) | ($urandom & 3));
      stall = $urandom_range(0, 7) == 0;
      reset = $urandom_range(0, 499) == 0;
      step();
    end
    reset = 1'b0;
    stall = 1'b0;
    rd(BASE);
    step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_timer_bank.md
# csr_timer_bank

Parametrised multi-channel timer CSR block for the LoongArch core: N independent down-counting timers, each with its own TCFG/TVAL/TICLR registers, plus a free-running stable counter. It sits beside the main CSR file on the same CSR read/write port, which is driven from the WB stage. It supplies a per-channel timer-interrupt vector that the main CSR file ORs into ESTAT.IS[11] and upward. It generalises the single architectural timer with channel count, counter width, a debug stall input and selectable set/clear priority.

## Interface
Parameters:
- N_TIMERS, 4: number of timer channels, 1..8.
- CNT_W, 32: counter width, 8..32; INITVAL field is CNT_W-2 bits.
- CSR_BASE, 14'h041: CSR number of channel 0 TCFG.
- SET_WINS, 1: if 1, a timer set beats a simultaneous TICLR clear; if 0, the clear wins.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- csr_we  in  1  CSR write enable.
- csr_num  in  14  CSR number.
- csr_wmask  in  32  write mask.
- csr_wvalue  in  32  write data.
- csr_rvalue  out  32  read data; combinational; 0 when there is no hit.
- csr_hit  out  1  csr_num decodes to a register in this block.
- timer_stall  in  1  debug halt; freezes all counters.
- timer_irq  out  N_TIMERS  per-channel pending bit.
- stable_cnt  out  64  free-running cycle counter.

## Operation
- Address map: channel c uses CSR_BASE+4c for TCFG, +4c+1 for TVAL, +4c+2 for TICLR. Offset +3 is unmapped and gives csr_hit=0.
- TCFG layout: [0] EN, [1] PERIODIC, [CNT_W-1:2] INITVAL. Bits above CNT_W-1 read 0 and ignore writes. Every field update is (mask & wvalue) | (~mask & old).
- TVAL: read-only. Reads the counter, zero-extended to 32 bits. Writes are ignored.
- TICLR: reads 0. A write with mask[0] & wvalue[0] clears that channel's pending bit.
- Counter load: any TCFG write whose post-mask EN value is 1 loads the counter with {new INITVAL, 2'b00}. This takes priority over counting.
- Counting: the counter decrements by 1 per cycle only when all of these hold: EN=1, timer_stall=0, counter ≠ all-ones.
  - At counter==0 with PERIODIC=1, the counter reloads {INITVAL, 2'b00} instead of decrementing.
  - At counter==0 with PERIODIC=0, the counter decrements to all-ones and stops there.
- Pending set: the pending bit sets on a cycle where EN=1, timer_stall=0 and counter==0. A simultaneous TICLR clear is resolved by SET_WINS.
- A TCFG write with EN=0 freezes the counter at its current value. Pending is unchanged.
- timer_irq[c] is the pending register output directly; there is no enable gating here.
- stable_cnt increments every cycle, including during timer_stall, and wraps at 2^64.
- Reset values:
  - EN, PERIODIC and INITVAL = 0.
  - Counters = all-ones.
  - Pending = 0.
  - stable_cnt = 0.
  - csr_rvalue and csr_hit follow the decode, combinationally, from reset values.

## Timing
- Registers update on posedge clk. Reads are combinational, so a read in the same cycle as a write returns the old value.
- TCFG write with EN=1 at edge t: TVAL = INITVAL*4 from t+1.
- TVAL reaches 0 after INITVAL*4 further unstalled cycles.
- Pending is sampled at the edge where TVAL==0. timer_irq is high from the next cycle.
- INITVAL=0 with EN=1: counter is 0 right after the load. Pending sets at the next edge; periodic mode then reloads 0 every cycle.
- Stall: while stalled, counters and pending-set hold. Counting resumes on the first cycle stall is low. TCFG loads and TICLR clears still take effect while stalled.
- Reset asserted mid-count: all state is forced to reset values immediately, not at the next edge. The first count happens no earlier than the first edge after deassertion plus a TCFG write.

## Structure
- Shared package holds:
  - Offset constants TCFG_OFS=0, TVAL_OFS=1, TICLR_OFS=2.
  - Field positions TCFG_EN=0, TCFG_PERIODIC=1.
  - TICLR_CLR=0.
- Sub-module csr_timer_chan: one channel, covering the TCFG register, counter, pending bit and its local decode. It is instantiated N_TIMERS times via generate.
- Top level holds the address decode, read mux (OR of per-channel read values), csr_hit and stable_cnt.

## Test plan
- One-shot, channel 0: write TCFG=0x0000000D (INITVAL=3, EN). TVAL reads 12,11,…,0, then 0xFFFFFFFF and holds. timer_irq[0] rises the cycle after TVAL==0 and stays high.
- Periodic, channel 2: write TCFG at CSR_BASE+8 = 0x0000000B (INITVAL=2, PERIODIC, EN). TVAL cycles 8..0,8..0. The pending bit is re-set each period. A TICLR write of 1 between periods drops timer_irq[2] for the following cycles until the next TVAL==0.
- Set/clear collision: TICLR write on the same edge as TVAL==0. With SET_WINS=1, timer_irq stays 1. With SET_WINS=0, timer_irq goes 0.
- Stall: assert timer_stall for 5 cycles with TVAL=7. TVAL holds 7 and stable_cnt advances by 5. Deassert stall and TVAL resumes at 6.
- Masked write: TCFG holds 0x21 (INITVAL=8, EN). Write wvalue=0x0, wmask=0x2 (PERIODIC bit only). TCFG reads 0x21, EN is unchanged, and the counter reloads to 32 because post-mask EN is still 1.
- Async reset mid-count: assert reset between edges while counting. TVAL reads 0xFFFFFFFF, timer_irq=0 and stable_cnt=0 before the next posedge. Unmapped CSR_BASE+3 reads 0 with csr_hit=0.
